// File: rtl/vend_pkg.sv
// Shared types and constants for the cola kiosk: arbiter state encoding and
// the coin/price values the per-panel vending FSMs agree on.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
    MOTOR      = 3'd2,
    PAY        = 3'd3,
    WAIT_SENSE = 3'd4,
    DONE       = 3'd5,
    HALT       = 3'd6
  } arb_state_t;

  localparam int COIN_VALUE = 5;
  localparam int PRICE      = 15;

  // Rs5 coins a panel owes back for a given amount paid in.
  function automatic int change_coins(input int paid);
    return (paid > PRICE) ? (paid - PRICE) / COIN_VALUE : 0;
  endfunction

endpackage

// File: rtl/vend_dispense_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping past the top index back to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  int pos;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(rr_ptr) + k) % N;
      if (!found && req[pos]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispenser motor and one Rs5 change hopper between NUM_REQ panel
// FSMs. Optional AUDIT_COUNT_EN adds saturating vend/coin audit counters.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CHG_W         = 2,
  parameter int MOTOR_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CHG_W-1:0]   change_cnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       motor_on,
  output logic                       hopper_pulse,
  input  logic                       hopper_sense,
  output logic                       fault,
`ifdef AUDIT_COUNT_EN
  output logic [15:0]                vend_count,
  output logic [15:0]                coin_count,
`endif
  output arb_state_t                 state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int MW = $clog2(MOTOR_CYCLES + 1);
  localparam int TW = $clog2(SENSE_TIMEOUT + 1);

  // Handshake: a panel raises req and holds it; the arbiter answers with a
  // one-cycle done[i] strobe. A request is consumed only by that strobe, so
  // req may drop early without cancelling a vend already granted.

  arb_state_t        state, next_state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_id_q;
  logic [CHG_W-1:0]  coins_left;
  logic [MW-1:0]     motor_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              fault_q;
  logic              sense_s1, sense_s2, sense_s3;
  logic              sense_rise;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [CHG_W-1:0]  coin_sel;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  assign coin_sel   = change_cnt[pick_idx*CHG_W +: CHG_W];
  assign sense_rise = sense_s2 & ~sense_s3;

  // s1/s2 resynchronise the hopper sensor; s3 holds the previous value for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sense_s1 <= 1'b0;
      sense_s2 <= 1'b0;
      sense_s3 <= 1'b0;
    end else begin
      sense_s1 <= hopper_sense;
      sense_s2 <= sense_s1;
      sense_s3 <= sense_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (pick_found) next_state = GRANT;
      GRANT:      next_state = MOTOR;
      MOTOR: begin
        if (motor_cnt == MW'(1))
          next_state = (coins_left != '0) ? PAY : DONE;
      end
      PAY:        next_state = WAIT_SENSE;
      WAIT_SENSE: begin
        if (sense_rise)
          next_state = (coins_left == CHG_W'(1)) ? DONE : PAY;
        else if (tmo_cnt == TW'(1))
          next_state = HALT;
      end
      DONE:       next_state = IDLE;
      HALT:       next_state = HALT;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      grant_id_q <= '0;
      coins_left <= '0;
      motor_cnt  <= '0;
      tmo_cnt    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_idx;
            coins_left <= coin_sel;
          end
        end
        GRANT: motor_cnt <= MW'(MOTOR_CYCLES);
        MOTOR: motor_cnt <= motor_cnt - MW'(1);
        PAY:   tmo_cnt   <= TW'(SENSE_TIMEOUT);
        WAIT_SENSE: begin
          if (sense_rise) begin
            coins_left <= coins_left - CHG_W'(1);
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
            if (tmo_cnt == TW'(1)) fault_q <= 1'b1;
          end
        end
        DONE: begin
          if (grant_id_q == IW'(NUM_REQ - 1)) rr_ptr <= '0;
          else                                rr_ptr <= grant_id_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    motor_on     = (state == MOTOR);
    hopper_pulse = (state == PAY);
    done         = '0;
    if (state == DONE) done[grant_id_q] = 1'b1;
  end

  assign grant_id  = grant_id_q;
  assign fault     = fault_q;
  assign state_dbg = state;

`ifdef AUDIT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_count <= '0;
      coin_count <= '0;
    end else begin
      if (state == DONE && vend_count != 16'hFFFF)
        vend_count <= vend_count + 16'd1;
      if (state == WAIT_SENSE && sense_rise && coin_count != 16'hFFFF)
        coin_count <= coin_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Bench for vend_dispense_arbiter: table of single vends plus hand sequences for
// fairness, sensor timeout, reset mid-motor and (with AUDIT_COUNT_EN) audit counts.
module tb_vend_dispense_arbiter;
  import vend_pkg::*;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] change_cnt = '0;
  logic            hopper_sense = 1'b0;
  logic [N-1:0]    done;
  logic [IW-1:0]   grant_id;
  logic            busy, motor_on, hopper_pulse, fault;
  arb_state_t      state_dbg;
`ifdef AUDIT_COUNT_EN
  logic [15:0]     vend_count, coin_count;
`endif

  vend_dispense_arbiter #(
    .NUM_REQ(N), .CHG_W(CW), .MOTOR_CYCLES(8), .SENSE_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .change_cnt   (change_cnt),
    .done         (done),
    .grant_id     (grant_id),
    .busy         (busy),
    .motor_on     (motor_on),
    .hopper_pulse (hopper_pulse),
    .hopper_sense (hopper_sense),
    .fault        (fault),
`ifdef AUDIT_COUNT_EN
    .vend_count   (vend_count),
    .coin_count   (coin_count),
`endif
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: everything is sampled on the falling edge.
  int cyc = 0;
  int pulse_cnt = 0, pulse_cyc = 0, motor_cnt = 0;
  int done_cnt = 0, done_cyc = 0, fault_cyc = -1;
  logic [N-1:0]  last_done = '0;
  logic [IW-1:0] grant_q[$];
  logic [IW-1:0] exp_q[$];
  bit sense_en = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (hopper_pulse) begin pulse_cnt++; pulse_cyc = cyc; end
    if (motor_on) motor_cnt++;
    if (done != '0) begin done_cnt++; done_cyc = cyc; last_done = done; end
    if (state_dbg == GRANT) grant_q.push_back(grant_id);
    if (fault && fault_cyc < 0) fault_cyc = cyc;
  end

  // Hopper model: coin passes the sensor 3 cycles after each eject pulse.
  always begin
    @(negedge clk);
    if (sense_en && hopper_pulse) begin
      repeat (3) @(posedge clk);
      #1 hopper_sense = 1'b1;
      repeat (3) @(posedge clk);
      #1 hopper_sense = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pulse_cnt = 0; motor_cnt = 0; fault_cyc = -1;
    grant_q.delete();
  endtask

  task automatic do_reset();
    req = '0; change_cnt = '0;
    reset = 1'b0;
    tick(); tick();
    clear_mon();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic vend_once(input logic [N-1:0] r, input logic [N*CW-1:0] c, output bit ok);
    change_cnt = c;
    req = r;
    wait_done(200, ok);
    req = '0;
    tick();
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N*CW-1:0] cnt;
    logic [N*CW-1:0] cnt_after;
    logic [IW-1:0]   exp_grant;
    int              exp_pulses;
    int              exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int c0;
    logic [N-1:0] oh;

    // Latency is counted from the IDLE cycle where req first appears (cycle 0):
    // 10 cycles for a no-change vend plus 6 per coin with the hopper model above.
    vecs[0] = '{4'b0010, 8'h00, 8'h00, 2'd1, 0, 10};
    vecs[1] = '{4'b0001, 8'h02, 8'h02, 2'd0, 2, 22};
    vecs[2] = '{4'b1100, 8'h30, 8'h30, 2'd2, 3, 28};
    vecs[3] = '{4'b0101, 8'h31, 8'hFF, 2'd0, 1, 16};
    vecs[4] = '{4'b1001, 8'h3F, 8'h3F, 2'd3, 0, 10};

    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_motor", motor_on, 0);
    check("rst_pulse", hopper_pulse, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_grant", grant_id, 0);
    check("rst_state", state_dbg, IDLE);
    clear_mon();
    reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      change_cnt = vecs[v].cnt;
      req = vecs[v].req;
      c0 = cyc;
      tick(); tick();
      change_cnt = vecs[v].cnt_after;
      wait_done(200, ok);
      req = '0;
      oh = '0;
      oh[vecs[v].exp_grant] = 1'b1;
      check($sformatf("v%0d_done_seen", v), ok, 1);
      check($sformatf("v%0d_grant", v), (grant_q.size() > 0) ? grant_q[0] : 'x, vecs[v].exp_grant);
      check($sformatf("v%0d_latency", v), done_cyc - c0, vecs[v].exp_lat);
      check($sformatf("v%0d_done_vec", v), last_done, oh);
      check($sformatf("v%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
      check($sformatf("v%0d_motor_cycles", v), motor_cnt, 8);
      check($sformatf("v%0d_fault", v), fault, 0);
      if (vecs[v].exp_pulses > 0)
        check($sformatf("v%0d_sense_to_done", v), done_cyc - pulse_cyc, 6);
      tick();
    end

    // Fairness: all four requesting, each drops after its own done.
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    change_cnt = '0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_done(100, ok);
      check($sformatf("rr_done%0d", i), ok, 1);
      req = req & ~last_done;
    end
    tick();
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      wait_done(100, ok);
      check($sformatf("rr2_done%0d", i), ok, 1);
      req = req & ~last_done;
    end
    tick();
    check("rr_grant_count", grant_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rr_order%0d", i), (i < grant_q.size()) ? grant_q[i] : 'x, exp_q[i]);

    // Sensor timeout: hopper never confirms.
    sense_en = 1'b0;
    clear_mon();
    change_cnt = 8'h10;
    req = 4'b0100;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fault) break;
    end
    req = '0;
    check("tmo_fault", fault, 1);
    check("tmo_pulses", pulse_cnt, 1);
    check("tmo_delay", fault_cyc - pulse_cyc, 17);
    check("tmo_state", state_dbg, HALT);
    check("tmo_busy", busy, 1);
    check("tmo_motor", motor_on, 0);
    c0 = done_cnt;
    req = 4'b0001;
    repeat (20) tick();
    check("halt_no_done", done_cnt, c0);
    check("halt_no_grant", grant_q.size(), 1);
    check("halt_state", state_dbg, HALT);
    check("halt_fault_sticky", fault, 1);
    do_reset();
    sense_en = 1'b1;
    check("post_rst_fault", fault, 0);
    check("post_rst_state", state_dbg, IDLE);

    // Reset during motor: rr_ptr must return to 0.
    vend_once(4'b0100, 8'h00, ok);
    check("pre_vend_done", ok, 1);
    clear_mon();
    req = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (motor_cnt >= 4) break;
    end
    check("mid_grant", (grant_q.size() > 0) ? grant_q[0] : 'x, 3);
    check("mid_motor_seen", motor_cnt, 4);
    req = 4'b1010;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_motor", motor_on, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_dbg, IDLE);
    tick(); tick();
    grant_q.delete();
    reset = 1'b1;
    wait_done(100, ok);
    req = '0;
    check("regrant_done", ok, 1);
    check("regrant_id", (grant_q.size() > 0) ? grant_q[0] : 'x, 1);
    check("regrant_vec", last_done, 4'b0010);
    tick();

`ifdef AUDIT_COUNT_EN
    do_reset();
    check("aud_rst_vend", vend_count, 0);
    check("aud_rst_coin", coin_count, 0);
    vend_once(4'b0100, 8'h00, ok);
    vend_once(4'b0001, 8'h01, ok);
    vend_once(4'b0010, 8'h08, ok);
    check("aud_vend_count", vend_count, 3);
    check("aud_coin_count", coin_count, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
